// File: rtl/regfile_bypass.sv
// Decode-stage register file: one synchronous write port and two combinational read ports.
// Optional same-cycle write-to-read bypass and optional hardwired-zero entry 0.
module regfile_bypass #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned ADDR_W   = 3,
    parameter bit          BYPASS   = 1'b1,
    parameter bit          ZERO_REG = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd1_sel,
    input  logic [ADDR_W-1:0] rd2_sel,
    input  logic [ADDR_W-1:0] wr_sel,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              wr,
    output logic [WIDTH-1:0]  rd1_data,
    output logic [WIDTH-1:0]  rd2_data,
    output logic              err
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] we;

    // Per-entry load enable; out-of-range and hardwired-zero writes never match
    always_comb begin
        we = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            we[i] = wr && (32'(wr_sel) == i) && !(ZERO_REG && (i == 0));
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (rst) begin
                mem[i] <= '0;
            end else if (we[i]) begin
                mem[i] <= wr_data;
            end
        end
    end

    // Stored value (0 when out of range or zero entry), overridden by an accepted same-cycle write
    function automatic logic [WIDTH-1:0] read_port(input logic [ADDR_W-1:0] sel);
        logic [WIDTH-1:0] val;
        val = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ((32'(sel) == i) && !(ZERO_REG && (i == 0))) begin
                val = mem[i];
            end
        end
        if (BYPASS && !rst && (|we) && (sel == wr_sel)) begin
            val = wr_data;
        end
        return val;
    endfunction

    always_comb begin
        rd1_data = read_port(rd1_sel);
        rd2_data = read_port(rd2_sel);
    end

    // Informational only: out-of-range selects or unknown control inputs
    always_comb begin
        err = (32'(rd1_sel) >= DEPTH)
            | (32'(rd2_sel) >= DEPTH)
            | (wr & (32'(wr_sel) >= DEPTH))
            | ((^{rd1_sel, rd2_sel, wr_sel, wr, rst}) === 1'bx);
    end

endmodule

// File: tb/tb_regfile_bypass.sv
// Bench for regfile_bypass: four configurations share one stimulus stream and are
// checked against an array-based model of the register file.
module tb_regfile_bypass;

    localparam int NI = 4;

    // inst 0: bypass, inst 1: no bypass, inst 2: zero reg, inst 3: DEPTH=6
    int unsigned dep [NI] = '{8, 8, 8, 6};
    bit          byp [NI] = '{1'b1, 1'b0, 1'b1, 1'b1};
    bit          zr  [NI] = '{1'b0, 1'b0, 1'b1, 1'b0};

    logic        clk;
    logic        rst;
    logic        wr;
    logic [2:0]  wr_sel;
    logic [15:0] wr_data;
    logic [2:0]  rd1_sel;
    logic [2:0]  rd2_sel;
    logic [15:0] rd1 [NI];
    logic [15:0] rd2 [NI];
    logic        er  [NI];

    logic [15:0] ref_mem [NI][8];
    int          checks = 0;
    int          errors = 0;

    regfile_bypass #(.WIDTH(16), .DEPTH(8), .ADDR_W(3), .BYPASS(1'b1), .ZERO_REG(1'b0)) u_byp (
        .clk(clk), .rst(rst), .rd1_sel(rd1_sel), .rd2_sel(rd2_sel), .wr_sel(wr_sel),
        .wr_data(wr_data), .wr(wr), .rd1_data(rd1[0]), .rd2_data(rd2[0]), .err(er[0]));
    regfile_bypass #(.WIDTH(16), .DEPTH(8), .ADDR_W(3), .BYPASS(1'b0), .ZERO_REG(1'b0)) u_nob (
        .clk(clk), .rst(rst), .rd1_sel(rd1_sel), .rd2_sel(rd2_sel), .wr_sel(wr_sel),
        .wr_data(wr_data), .wr(wr), .rd1_data(rd1[1]), .rd2_data(rd2[1]), .err(er[1]));
    regfile_bypass #(.WIDTH(16), .DEPTH(8), .ADDR_W(3), .BYPASS(1'b1), .ZERO_REG(1'b1)) u_zero (
        .clk(clk), .rst(rst), .rd1_sel(rd1_sel), .rd2_sel(rd2_sel), .wr_sel(wr_sel),
        .wr_data(wr_data), .wr(wr), .rd1_data(rd1[2]), .rd2_data(rd2[2]), .err(er[2]));
    regfile_bypass #(.WIDTH(16), .DEPTH(6), .ADDR_W(3), .BYPASS(1'b1), .ZERO_REG(1'b0)) u_oor (
        .clk(clk), .rst(rst), .rd1_sel(rd1_sel), .rd2_sel(rd2_sel), .wr_sel(wr_sel),
        .wr_data(wr_data), .wr(wr), .rd1_data(rd1[3]), .rd2_data(rd2[3]), .err(er[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected read value for instance k from the current inputs and the model contents
    function automatic logic [15:0] exp_read(input int k, input logic [2:0] sel);
        if (int'(sel) >= int'(dep[k])) return 16'h0;
        if (zr[k] && sel == 3'd0) return 16'h0;
        if (byp[k] && wr && !rst && wr_sel == sel) return wr_data;
        return ref_mem[k][sel];
    endfunction

    function automatic logic exp_err(input int k);
        return (int'(rd1_sel) >= int'(dep[k])) || (int'(rd2_sel) >= int'(dep[k]))
            || (wr && int'(wr_sel) >= int'(dep[k]));
    endfunction

    // Apply inputs shortly after an edge and let the combinational outputs settle
    task automatic drive(input logic r, input logic w, input logic [2:0] ws,
                         input logic [15:0] wd, input logic [2:0] s1, input logic [2:0] s2);
        rst = r; wr = w; wr_sel = ws; wr_data = wd; rd1_sel = s1; rd2_sel = s2;
        #2;
    endtask

    // Advance one edge and update the model with what the edge should have stored
    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < NI; k++) begin
            if (rst) begin
                for (int a = 0; a < 8; a++) ref_mem[k][a] = 16'h0;
            end else if (wr && int'(wr_sel) < int'(dep[k]) && !(zr[k] && wr_sel == 3'd0)) begin
                ref_mem[k][wr_sel] = wr_data;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 3'd2, 16'hDEAD, 3'd0, 3'd0);
        tick();
        for (int s = 0; s < 8; s++) begin
            drive(1'b0, 1'b0, 3'd0, 16'h0, 3'(s), 3'(7 - s));
            for (int k = 0; k < NI; k++) begin
                checks++;
                if (rd1[k] !== 16'h0 || rd2[k] !== 16'h0) begin
                    errors++;
                    $display("FAIL reset_read inst%0d sel%0d got %h/%h exp 0000/0000", k, s, rd1[k], rd2[k]);
                end
                checks++;
                if (er[k] !== exp_err(k)) begin
                    errors++;
                    $display("FAIL reset_err inst%0d sel%0d got %b exp %b", k, s, er[k], exp_err(k));
                end
            end
        end
    endtask

    task automatic test_write_read();
        drive(1'b0, 1'b1, 3'd3, 16'hA5A5, 3'd3, 3'd3);
        checks++;
        if (rd1[1] !== 16'h0000) begin
            errors++;
            $display("FAIL nobypass_same_cycle got %h exp 0000", rd1[1]);
        end
        tick();
        drive(1'b0, 1'b0, 3'd0, 16'h0, 3'd3, 3'd3);
        checks++;
        if (rd1[1] !== 16'hA5A5 || rd2[1] !== 16'hA5A5) begin
            errors++;
            $display("FAIL write_read got %h/%h exp a5a5/a5a5", rd1[1], rd2[1]);
        end
        drive(1'b0, 1'b0, 3'd0, 16'h0, 3'd2, 3'd4);
        checks++;
        if (rd1[1] !== 16'h0000 || rd2[1] !== 16'h0000) begin
            errors++;
            $display("FAIL neighbours got %h/%h exp 0000/0000", rd1[1], rd2[1]);
        end
    endtask

    task automatic test_bypass();
        drive(1'b0, 1'b1, 3'd4, 16'h4444, 3'd0, 3'd0);
        tick();
        drive(1'b0, 1'b1, 3'd5, 16'h5555, 3'd0, 3'd0);
        tick();
        drive(1'b0, 1'b1, 3'd5, 16'h1234, 3'd5, 3'd4);
        checks++;
        if (rd1[0] !== 16'h1234 || rd2[0] !== 16'h4444) begin
            errors++;
            $display("FAIL bypass_port1 got %h/%h exp 1234/4444", rd1[0], rd2[0]);
        end
        checks++;
        if (rd1[1] !== 16'h5555) begin
            errors++;
            $display("FAIL nobypass_old got %h exp 5555", rd1[1]);
        end
        tick();
        drive(1'b0, 1'b0, 3'd5, 16'h0, 3'd5, 3'd4);
        checks++;
        if (rd1[1] !== 16'h1234) begin
            errors++;
            $display("FAIL nobypass_after_edge got %h exp 1234", rd1[1]);
        end
        drive(1'b0, 1'b1, 3'd6, 16'h6A6A, 3'd6, 3'd6);
        checks++;
        if (rd1[0] !== 16'h6A6A || rd2[0] !== 16'h6A6A) begin
            errors++;
            $display("FAIL bypass_both got %h/%h exp 6a6a/6a6a", rd1[0], rd2[0]);
        end
        tick();
    endtask

    task automatic test_reset_collision();
        drive(1'b0, 1'b1, 3'd1, 16'h0111, 3'd1, 3'd1);
        tick();
        drive(1'b1, 1'b1, 3'd1, 16'hFFFF, 3'd1, 3'd1);
        checks++;
        if (rd1[0] !== 16'h0111 || rd2[0] !== 16'h0111) begin
            errors++;
            $display("FAIL rst_suppresses_bypass got %h/%h exp 0111/0111", rd1[0], rd2[0]);
        end
        tick();
        drive(1'b0, 1'b0, 3'd0, 16'h0, 3'd1, 3'd6);
        for (int k = 0; k < NI; k++) begin
            checks++;
            if (rd1[k] !== 16'h0000) begin
                errors++;
                $display("FAIL rst_wins_write inst%0d got %h exp 0000", k, rd1[k]);
            end
        end
    endtask

    task automatic test_zero_reg();
        drive(1'b0, 1'b1, 3'd0, 16'hBEEF, 3'd0, 3'd1);
        checks++;
        if (rd1[2] !== 16'h0000 || er[2] !== 1'b0) begin
            errors++;
            $display("FAIL zero_same_cycle got %h err %b exp 0000 err 0", rd1[2], er[2]);
        end
        checks++;
        if (rd1[0] !== 16'hBEEF) begin
            errors++;
            $display("FAIL entry0_normal_bypass got %h exp beef", rd1[0]);
        end
        tick();
        drive(1'b0, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0);
        checks++;
        if (rd1[2] !== 16'h0000 || rd2[2] !== 16'h0000) begin
            errors++;
            $display("FAIL zero_next_cycle got %h/%h exp 0000/0000", rd1[2], rd2[2]);
        end
        checks++;
        if (rd1[0] !== 16'hBEEF) begin
            errors++;
            $display("FAIL entry0_normal_store got %h exp beef", rd1[0]);
        end
        drive(1'b0, 1'b1, 3'd7, 16'h7777, 3'd7, 3'd0);
        checks++;
        if (rd1[2] !== 16'h7777) begin
            errors++;
            $display("FAIL zero_inst_entry7_bypass got %h exp 7777", rd1[2]);
        end
        tick();
        drive(1'b0, 1'b0, 3'd0, 16'h0, 3'd7, 3'd0);
        checks++;
        if (rd1[2] !== 16'h7777) begin
            errors++;
            $display("FAIL zero_inst_entry7 got %h exp 7777", rd1[2]);
        end
    endtask

    task automatic test_out_of_range();
        drive(1'b0, 1'b1, 3'd6, 16'hC0DE, 3'd0, 3'd1);
        checks++;
        if (er[3] !== 1'b1 || er[0] !== 1'b0) begin
            errors++;
            $display("FAIL oor_write_err got %b/%b exp 1/0", er[3], er[0]);
        end
        tick();
        for (int s = 0; s < 6; s++) begin
            drive(1'b0, 1'b0, 3'd0, 16'h0, 3'(s), 3'(s));
            checks++;
            if (rd1[3] !== ref_mem[3][s]) begin
                errors++;
                $display("FAIL oor_image sel%0d got %h exp %h", s, rd1[3], ref_mem[3][s]);
            end
        end
        drive(1'b0, 1'b0, 3'd0, 16'h0, 3'd2, 3'd7);
        checks++;
        if (rd2[3] !== 16'h0000 || er[3] !== 1'b1) begin
            errors++;
            $display("FAIL oor_read got %h err %b exp 0000 err 1", rd2[3], er[3]);
        end
        drive(1'b0, 1'b0, 3'd7, 16'h0, 3'd5, 3'd0);
        checks++;
        if (er[3] !== 1'b0) begin
            errors++;
            $display("FAIL oor_idle_err got %b exp 0", er[3]);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            drive(($urandom_range(19) == 0), ($urandom_range(3) != 0), 3'($urandom_range(7)),
                  16'($urandom), 3'($urandom_range(7)), 3'($urandom_range(7)));
            for (int k = 0; k < NI; k++) begin
                checks++;
                if (rd1[k] !== exp_read(k, rd1_sel) || rd2[k] !== exp_read(k, rd2_sel)
                    || er[k] !== exp_err(k)) begin
                    errors++;
                    $display("FAIL random n%0d inst%0d got %h/%h/%b exp %h/%h/%b", n, k,
                             rd1[k], rd2[k], er[k], exp_read(k, rd1_sel), exp_read(k, rd2_sel),
                             exp_err(k));
                end
            end
            tick();
        end
    endtask

    initial begin
        drive(1'b1, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0);
        tick();
        test_reset();
        test_write_read();
        test_bypass();
        test_reset_collision();
        test_zero_reg();
        test_out_of_range();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
